// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU opcodes, datapath width and held-instruction record
package alu_issue_stage_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0] reg_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef struct packed {
    logic [3:0] op;
    word_t      ra;
    word_t      rb;
    reg_t       rd;
    word_t      pc;
    reg_t       rs1;
    reg_t       rs2;
    logic       use1;
    logic       use2;
  } held_t;
  function automatic logic bus_hit(input logic v, input reg_t rd, input reg_t rs);
    return v && rs != '0 && rd == rs;
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decode, forwarding-bus and ALU-side signals of the issue stage
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;
  logic       i_id_valid;
  logic       o_id_ready;
  logic [3:0] i_id_op;
  reg_t       i_id_rs1;
  reg_t       i_id_rs2;
  reg_t       i_id_rd;
  word_t      i_id_rs1_data;
  word_t      i_id_rs2_data;
  word_t      i_id_imm;
  logic       i_id_use_imm;
  logic       i_id_use_pc;
  word_t      i_id_pc;
  logic       i_mem_fwd_valid;
  reg_t       i_mem_rd;
  word_t      i_mem_data;
  logic       i_wb_fwd_valid;
  reg_t       i_wb_rd;
  word_t      i_wb_data;
  logic       i_ld_pending;
  reg_t       i_ld_rd;
  logic       i_flush;
  logic       o_ex_valid;
  logic       i_ex_ready;
  logic [3:0] o_alu_op;
  word_t      o_alu_ra;
  word_t      o_alu_rb;
  reg_t       o_rd;
  word_t      o_pc;
  modport slave (
    input  i_id_valid, i_id_op, i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_use_imm, i_id_use_pc, i_id_pc, i_mem_fwd_valid, i_mem_rd, i_mem_data,
           i_wb_fwd_valid, i_wb_rd, i_wb_data, i_ld_pending, i_ld_rd, i_flush, i_ex_ready,
    output o_id_ready, o_ex_valid, o_alu_op, o_alu_ra, o_alu_rb, o_rd, o_pc
  );
  modport master (
    output i_id_valid, i_id_op, i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_data, i_id_rs2_data,
           i_id_imm, i_id_use_imm, i_id_use_pc, i_id_pc, i_mem_fwd_valid, i_mem_rd, i_mem_data,
           i_wb_fwd_valid, i_wb_rd, i_wb_data, i_ld_pending, i_ld_rd, i_flush, i_ex_ready,
    input  o_id_ready, o_ex_valid, o_alu_op, o_alu_ra, o_alu_rb, o_rd, o_pc
  );
endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// fwd_mux: picks MEM over WB over the fallback data for one source register
module fwd_mux
  import alu_issue_stage_pkg::*;
(
  input  reg_t  rs_i,
  input  word_t rf_data_i,
  input  logic  mem_valid_i,
  input  reg_t  mem_rd_i,
  input  word_t mem_data_i,
  input  logic  wb_valid_i,
  input  reg_t  wb_rd_i,
  input  word_t wb_data_i,
  output word_t data_o
);
  assign data_o = bus_hit(mem_valid_i, mem_rd_i, rs_i) ? mem_data_i :
                  bus_hit(wb_valid_i, wb_rd_i, rs_i)   ? wb_data_i  : rf_data_i;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with operand forwarding, load-use stall and stall-time snooping
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input logic i_clk,
  input logic i_rst_n,
  alu_issue_stage_if.slave bus
);
  held_t h_q, h_d;
  logic  valid_q, valid_d;
  logic  use1, use2, hazard, id_ready, capture, stall;
  word_t cap1, cap2, snp1, snp2;
  assign use1     = ~bus.i_id_use_pc;
  assign use2     = ~bus.i_id_use_imm;
  assign hazard   = bus.i_ld_pending && bus.i_ld_rd != '0 &&
                    ((use1 && bus.i_ld_rd == bus.i_id_rs1) || (use2 && bus.i_ld_rd == bus.i_id_rs2));
  assign id_ready = (~valid_q | bus.i_ex_ready) & ~hazard & ~bus.i_flush;
  assign capture  = bus.i_id_valid & id_ready;
  assign stall    = valid_q & ~bus.i_ex_ready;
  fwd_mux u_cap1 (.rs_i(bus.i_id_rs1), .rf_data_i(bus.i_id_rs1_data),
    .mem_valid_i(bus.i_mem_fwd_valid), .mem_rd_i(bus.i_mem_rd), .mem_data_i(bus.i_mem_data),
    .wb_valid_i(bus.i_wb_fwd_valid), .wb_rd_i(bus.i_wb_rd), .wb_data_i(bus.i_wb_data), .data_o(cap1));
  fwd_mux u_cap2 (.rs_i(bus.i_id_rs2), .rf_data_i(bus.i_id_rs2_data),
    .mem_valid_i(bus.i_mem_fwd_valid), .mem_rd_i(bus.i_mem_rd), .mem_data_i(bus.i_mem_data),
    .wb_valid_i(bus.i_wb_fwd_valid), .wb_rd_i(bus.i_wb_rd), .wb_data_i(bus.i_wb_data), .data_o(cap2));
  // Snoop muxes fall back to the held operand, so a miss leaves it untouched
  fwd_mux u_snp1 (.rs_i(h_q.rs1), .rf_data_i(h_q.ra),
    .mem_valid_i(bus.i_mem_fwd_valid), .mem_rd_i(bus.i_mem_rd), .mem_data_i(bus.i_mem_data),
    .wb_valid_i(bus.i_wb_fwd_valid), .wb_rd_i(bus.i_wb_rd), .wb_data_i(bus.i_wb_data), .data_o(snp1));
  fwd_mux u_snp2 (.rs_i(h_q.rs2), .rf_data_i(h_q.rb),
    .mem_valid_i(bus.i_mem_fwd_valid), .mem_rd_i(bus.i_mem_rd), .mem_data_i(bus.i_mem_data),
    .wb_valid_i(bus.i_wb_fwd_valid), .wb_rd_i(bus.i_wb_rd), .wb_data_i(bus.i_wb_data), .data_o(snp2));
  always_comb begin
    h_d = h_q;
    if (capture) begin
      h_d = '{op: bus.i_id_op, ra: use1 ? cap1 : bus.i_id_pc, rb: use2 ? cap2 : bus.i_id_imm,
              rd: bus.i_id_rd, pc: bus.i_id_pc, rs1: bus.i_id_rs1, rs2: bus.i_id_rs2,
              use1: use1, use2: use2};
    end else if (stall) begin
      h_d.ra = h_q.use1 ? snp1 : h_q.ra;
      h_d.rb = h_q.use2 ? snp2 : h_q.rb;
    end
  end
  assign valid_d = ~bus.i_flush & (capture | stall);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      valid_q <= valid_d;
    end
  end
  assign bus.o_id_ready = id_ready;
  assign bus.o_ex_valid = valid_q;
  assign bus.o_alu_op   = h_q.op;
  assign bus.o_alu_ra   = h_q.ra;
  assign bus.o_alu_rb   = h_q.rb;
  assign bus.o_rd       = h_q.rd;
  assign bus.o_pc       = h_q.pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus randomized checks against a behavioural issue-stage model
module tb_alu_issue_stage;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  alu_issue_stage_if b ();
  alu_issue_stage dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b));
  always #5 i_clk = ~i_clk;

  logic        m_valid, m_u1, m_u2;
  logic [3:0]  m_op;
  logic [31:0] m_ra, m_rb, m_pc;
  logic [4:0]  m_rd, m_rs1, m_rs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mfwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs != 0 && b.i_mem_fwd_valid && b.i_mem_rd == rs) return b.i_mem_data;
    if (rs != 0 && b.i_wb_fwd_valid && b.i_wb_rd == rs) return b.i_wb_data;
    return d;
  endfunction

  function automatic logic m_ready();
    logic hz;
    hz = b.i_ld_pending && b.i_ld_rd != 0 &&
         ((!b.i_id_use_pc && b.i_ld_rd == b.i_id_rs1) || (!b.i_id_use_imm && b.i_ld_rd == b.i_id_rs2));
    return (!m_valid || b.i_ex_ready) && !hz && !b.i_flush;
  endfunction

  task automatic m_reset();
    {m_valid, m_u1, m_u2, m_op, m_ra, m_rb, m_pc, m_rd, m_rs1, m_rs2} = '0;
  endtask

  task automatic m_step();
    logic rdy;
    rdy = m_ready();
    if (b.i_id_valid && rdy) begin
      m_op  = b.i_id_op;
      m_ra  = b.i_id_use_pc ? b.i_id_pc : mfwd(b.i_id_rs1, b.i_id_rs1_data);
      m_rb  = b.i_id_use_imm ? b.i_id_imm : mfwd(b.i_id_rs2, b.i_id_rs2_data);
      m_rd  = b.i_id_rd;
      m_pc  = b.i_id_pc;
      m_rs1 = b.i_id_rs1;
      m_rs2 = b.i_id_rs2;
      m_u1  = !b.i_id_use_pc;
      m_u2  = !b.i_id_use_imm;
      m_valid = 1'b1;
    end else begin
      if (m_valid && !b.i_ex_ready) begin
        if (m_u1) m_ra = mfwd(m_rs1, m_ra);
        if (m_u2) m_rb = mfwd(m_rs2, m_rb);
      end
      m_valid = m_valid && !b.i_ex_ready && !b.i_flush;
    end
  endtask

  task automatic chk_outs(input string p);
    chk({p, "_valid"}, 32'(b.o_ex_valid), 32'(m_valid));
    chk({p, "_op"}, 32'(b.o_alu_op), 32'(m_op));
    chk({p, "_ra"}, b.o_alu_ra, m_ra);
    chk({p, "_rb"}, b.o_alu_rb, m_rb);
    chk({p, "_rd"}, 32'(b.o_rd), 32'(m_rd));
    chk({p, "_pc"}, b.o_pc, m_pc);
  endtask

  task automatic cycle();
    #1 chk("id_ready", 32'(b.o_id_ready), 32'(m_ready()));
    @(posedge i_clk);
    m_step();
    @(negedge i_clk);
    chk_outs("out");
  endtask

  task automatic idle();
    b.i_id_valid = 0; b.i_id_op = 0; b.i_id_rs1 = 0; b.i_id_rs2 = 0; b.i_id_rd = 0;
    b.i_id_rs1_data = 0; b.i_id_rs2_data = 0; b.i_id_imm = 0; b.i_id_use_imm = 0;
    b.i_id_use_pc = 0; b.i_id_pc = 0; b.i_mem_fwd_valid = 0; b.i_mem_rd = 0; b.i_mem_data = 0;
    b.i_wb_fwd_valid = 0; b.i_wb_rd = 0; b.i_wb_data = 0; b.i_ld_pending = 0; b.i_ld_rd = 0;
    b.i_flush = 0; b.i_ex_ready = 1;
  endtask

  task automatic dec(input logic [3:0] op, input logic [4:0] rs1, rs2, rd,
                     input logic [31:0] d1, d2, imm, pc, input logic ui, up);
    b.i_id_valid = 1; b.i_id_op = op; b.i_id_rs1 = rs1; b.i_id_rs2 = rs2; b.i_id_rd = rd;
    b.i_id_rs1_data = d1; b.i_id_rs2_data = d2; b.i_id_imm = imm; b.i_id_pc = pc;
    b.i_id_use_imm = ui; b.i_id_use_pc = up;
  endtask

  initial begin
    idle();
    m_reset();
    #2;
    chk("rst_ready", 32'(b.o_id_ready), 32'd1);
    chk_outs("rst");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
    // independent ADD stream at full throughput
    dec(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h100, 0, 0);
    cycle();
    chk("add_ra", b.o_alu_ra, 32'd5);
    chk("add_rb", b.o_alu_rb, 32'd7);
    for (int i = 0; i < 4; i++) begin
      dec(4'(i), 5'(i + 10), 5'(i + 11), 5'(i + 1), 32'(i * 3), 32'(i * 5), 32'd0, 32'(i * 4), 0, 0);
      cycle();
      chk("stream_valid", 32'(b.o_ex_valid), 32'd1);
      chk("stream_ra", b.o_alu_ra, 32'(i * 3));
    end
    // forward priority
    idle();
    b.i_mem_fwd_valid = 1; b.i_mem_rd = 3; b.i_mem_data = 32'hAA;
    b.i_wb_fwd_valid = 1; b.i_wb_rd = 3; b.i_wb_data = 32'hBB;
    dec(4'd0, 5'd3, 5'd0, 5'd5, 32'h11, 32'h22, 32'd0, 32'h200, 0, 0);
    cycle();
    chk("fwd_mem_wins", b.o_alu_ra, 32'hAA);
    dec(4'd0, 5'd0, 5'd0, 5'd5, 32'h11, 32'h22, 32'd0, 32'h204, 0, 0);
    cycle();
    chk("fwd_x0", b.o_alu_ra, 32'h11);
    // load-use stall then MEM delivery
    idle();
    b.i_ld_pending = 1; b.i_ld_rd = 4;
    dec(4'd1, 5'd1, 5'd4, 5'd6, 32'd1, 32'h99, 32'd0, 32'h300, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("ldu_ready", 32'(b.o_id_ready), 32'd0);
      cycle();
    end
    b.i_ld_pending = 0;
    b.i_mem_fwd_valid = 1; b.i_mem_rd = 4; b.i_mem_data = 32'h1234;
    cycle();
    chk("ldu_rb", b.o_alu_rb, 32'h1234);
    chk("ldu_valid", 32'(b.o_ex_valid), 32'd1);
    // stall snoop; immediate operand must not be touched
    idle();
    dec(4'd2, 5'd9, 5'd9, 5'd7, 32'h1, 32'h2, 32'h77, 32'h400, 1, 0);
    cycle();
    idle();
    b.i_ex_ready = 0;
    b.i_wb_fwd_valid = 1; b.i_wb_rd = 9; b.i_wb_data = 32'h55;
    cycle();
    chk("snoop_ra", b.o_alu_ra, 32'h55);
    chk("snoop_rb_imm", b.o_alu_rb, 32'h77);
    // flush with a held instruction and a decode instruction
    b.i_wb_fwd_valid = 0;
    dec(4'd3, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'd0, 32'h500, 0, 0);
    b.i_flush = 1;
    #1 chk("flush_ready", 32'(b.o_id_ready), 32'd0);
    cycle();
    chk("flush_valid", 32'(b.o_ex_valid), 32'd0);
    // asynchronous reset mid-stall
    idle();
    dec(4'd4, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'd0, 32'h600, 0, 0);
    cycle();
    idle();
    b.i_ex_ready = 0;
    cycle();
    chk("pre_rst_valid", 32'(b.o_ex_valid), 32'd1);
    #2 i_rst_n = 0;
    m_reset();
    #1;
    chk("arst_valid", 32'(b.o_ex_valid), 32'd0);
    chk_outs("arst");
    @(negedge i_clk);
    i_rst_n = 1;
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      b.i_id_valid = ($urandom_range(9) < 7);
      b.i_id_op = 4'($urandom_range(9));
      b.i_id_rs1 = 5'($urandom_range(7));
      b.i_id_rs2 = 5'($urandom_range(7));
      b.i_id_rd = 5'($urandom_range(31));
      b.i_id_rs1_data = $urandom; b.i_id_rs2_data = $urandom;
      b.i_id_imm = $urandom; b.i_id_pc = $urandom;
      b.i_id_use_imm = ($urandom_range(3) == 0);
      b.i_id_use_pc = ($urandom_range(6) == 0);
      b.i_mem_fwd_valid = $urandom_range(1); b.i_mem_rd = 5'($urandom_range(7)); b.i_mem_data = $urandom;
      b.i_wb_fwd_valid = $urandom_range(1); b.i_wb_rd = 5'($urandom_range(7)); b.i_wb_data = $urandom;
      b.i_ld_pending = ($urandom_range(4) == 0); b.i_ld_rd = 5'($urandom_range(7));
      b.i_flush = ($urandom_range(19) == 0);
      b.i_ex_ready = ($urandom_range(4) < 3);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline register that assembles and holds the ALU operands. It takes decoded instructions from decode and resolves register data hazards by forwarding from the MEM and WB stages. It then presents a stable `op`/`Ra`/`Rb` triple to the combinational ALU under a valid/ready handshake. It also detects load-use hazards and keeps held operands current by snooping the forwarding buses while stalled.

## Interface
- `XLEN`, 32, datapath width
- `i_clk` in 1: clock, all state updates on rising edge
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_id_valid` in 1: decode presents an instruction
- `o_id_ready` out 1: stage accepts the decode instruction this cycle
- `i_id_op` in 4: ALU opcode (shared ALU opcode encoding)
- `i_id_rs1`, `i_id_rs2` in 5: source register indices
- `i_id_rd` in 5: destination index
- `i_id_rs1_data`, `i_id_rs2_data` in XLEN: register-file read data
- `i_id_imm` in XLEN: sign-extended immediate
- `i_id_use_imm` in 1: Rb comes from imm, not rs2
- `i_id_use_pc` in 1: Ra comes from pc, not rs1
- `i_id_pc` in XLEN: instruction PC
- `i_mem_fwd_valid` in 1, `i_mem_rd` in 5, `i_mem_data` in XLEN: final result in MEM
- `i_wb_fwd_valid` in 1, `i_wb_rd` in 5, `i_wb_data` in XLEN: writeback bus
- `i_ld_pending` in 1, `i_ld_rd` in 5: load in flight whose data is not yet on either bus
- `i_flush` in 1: kill the held instruction and the decode instruction
- `o_ex_valid` out 1: ALU operands valid
- `i_ex_ready` in 1: downstream consumes this cycle
- `o_alu_op` out 4, `o_alu_ra` out XLEN, `o_alu_rb` out XLEN: ALU inputs
- `o_rd` out 5, `o_pc` out XLEN: passed through with the instruction

## Operation
- Register source n "uses reg":
  - rs1 uses reg when `~use_pc`.
  - rs2 uses reg when `~use_imm`.
  - An index of 0 never matches any bus.
- Forward select per used source:
  - The MEM match (`mem_fwd_valid & mem_rd==rs`) wins.
  - Otherwise the WB match.
  - Otherwise register-file data.
- Ra selection: `use_pc` selects `pc`, otherwise forwarded rs1.
- Rb selection: `use_imm` selects `imm`, otherwise forwarded rs2.
- Load-use hazard: `i_ld_pending & ld_rd!=0 & ld_rd` equals a used source of the decode instruction.
- Acceptance:
  - `o_id_ready = (~o_ex_valid | i_ex_ready) & ~hazard & ~i_flush`.
  - Capture happens on `i_id_valid & o_id_ready`.
- Held-instruction state: op, Ra, Rb, rd, pc, plus the rs1/rs2 indices and their uses-reg flags.
- Snoop while held and not consumed (`o_ex_valid & ~i_ex_ready`):
  - Each uses-reg operand is overwritten by the forward select (MEM over WB) whenever a bus matches.
  - Immediate and PC operands are never overwritten.
- Flush: `o_ex_valid` is cleared at the next edge. No capture occurs in that cycle, regardless of the other inputs.
- `o_ex_valid` update:
  - Set when a capture occurs.
  - Cleared when a consume occurs without a capture.
  - Consume and capture in the same cycle is a back-to-back replace; `o_ex_valid` stays 1.
- Data outputs are held unchanged when there is no capture and no snoop.
- The ALU opcode encoding is not interpreted.

## Timing
- Reset values: `o_ex_valid=0`, `o_alu_op=0`, `o_alu_ra=0`, `o_alu_rb=0`, `o_rd=0`, `o_pc=0`, and all internal state 0. `o_id_ready=1` while `i_rst_n=0`, unless the hazard or `i_flush` term is active.
- Latency: 1 cycle from accepted decode to `o_ex_valid`. Full throughput of one instruction per cycle when `i_ex_ready` is held at 1.
- `o_id_ready` is combinational from `i_ex_ready`, `i_flush` and the hazard term. Decode must not depend on it to drive `i_id_valid`.
- Outputs are registered. They are stable while `o_ex_valid & ~i_ex_ready`, except for snoop updates.
- A hazard persists while `i_ld_pending` stays asserted. When the load arrives on MEM, decode is accepted that cycle with the forwarded value.
- Asserting `i_rst_n` low mid-handshake drops `o_ex_valid` immediately (asynchronously). Nothing is replayed.

## Structure
- The shared package holds the ALU opcode constants (`ALU_ADD`…`ALU_AND`) and the XLEN default.
- The sub-module `fwd_mux` (combinational) takes `rs`, `rf_data` and both buses and returns forwarded data. It is instantiated 4 times: capture and snoop, for each of rs1 and rs2.

## Test plan
- Independent ADD stream, `i_ex_ready=1`:
  - rs1 data 5, rs2 data 7 → cycle+1 shows `o_alu_ra=5`, `o_alu_rb=7`.
  - One instruction issues per cycle.
- Forward priority:
  - `mem_rd=wb_rd=rs1=3`, mem data 0xAA, wb data 0xBB → `o_alu_ra=0xAA`.
  - Same with rs1=0 → register-file data.
- Load-use:
  - `i_ld_pending=1`, `ld_rd=4`, rs2=4 for 3 cycles → `o_id_ready=0` for those cycles.
  - MEM then delivers 0x1234 with `rd=4` → capture, `o_alu_rb=0x1234`.
- Stall snoop:
  - Held instruction with rs1=9, `i_ex_ready=0`; WB writes `rd=9`, data 0x55 → `o_alu_ra` becomes 0x55 next cycle.
  - With `use_imm=1`, rs2=9 must leave Rb unchanged.
- Flush with `i_id_valid=1` and a held instruction → `o_id_ready=0`, and `o_ex_valid=0` next cycle.
- Async reset pulse mid-stall → `o_ex_valid` is 0 before the next clock edge and all outputs are 0.
